// File: rtl/seq_mult_engine_if.sv
// seq_mult_engine_if: operand/product handshakes plus abort and busy status
// for the shift-add sequential multiplier. The master drives operands and
// consumes products. The slave is the engine itself.
interface seq_mult_engine_if #(
  parameter int WIDTH_M = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH_M-1:0]     multiplicand;
  logic [WIDTH_M-1:0]     multiplier;
  logic                   abort;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH_M-1:0]   product;
  logic                   busy;

  modport master (
    output in_valid, multiplicand, multiplier, abort, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, multiplicand, multiplier, abort, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/seq_mult_engine.sv
// seq_mult_engine: unsigned WIDTH_M x WIDTH_M shift-add multiplier.
// Each CALC cycle does a conditional add of M into A, then shifts {C,A,Q}
// right by one bit. The product {A,Q} is presented until it is consumed.
// An abort in CALC or DONE drops the operation.
// Optional feature macro: EARLY_TERM_EN. When it is defined, the engine
// finishes with one bulk shift as soon as no unprocessed multiplier bits
// remain set.
module seq_mult_engine #(
  parameter int WIDTH_M = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  seq_mult_engine_if.slave   bus
);

  localparam int REM_W = $clog2(WIDTH_M + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]         state;
  logic [WIDTH_M-1:0] m_q;
  logic [WIDTH_M-1:0] a_q;
  logic [WIDTH_M-1:0] q_q;
  logic               c_q;
  logic [REM_W-1:0]   rem;
  logic [WIDTH_M:0]   sum;

  // Conditional add. C is the accumulator's extension bit and is always zero
  // when a step starts, so {C,A} + M is the spec's (WIDTH_M+1)-bit sum.
  // NOTE: always_comb gives sum a value on every path, so no latch is inferred.
  always_comb begin
    sum = {c_q, a_q};
    if (q_q[0]) sum = {c_q, a_q} + {1'b0, m_q};
  end

`ifdef EARLY_TERM_EN
  logic [WIDTH_M-1:0] live_mask;

  // Marks the multiplier bits that have not been consumed yet (the low rem bits of Q).
  always_comb begin
    live_mask = ~({WIDTH_M{1'b1}} << rem);
  end
`endif

  // Control FSM and datapath registers. Abort takes priority over step
  // completion and over the output handshake.
  // NOTE: state registers use non-blocking assignments, so every register
  // samples its pre-edge value and update order never matters.
  // NOTE: all datapath registers reset to zero, so the product port reads 0 after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      m_q   <= '0;
      a_q   <= '0;
      q_q   <= '0;
      c_q   <= 1'b0;
      rem   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            m_q   <= bus.multiplicand;
            q_q   <= bus.multiplier;
            a_q   <= '0;
            c_q   <= 1'b0;
            rem   <= REM_W'(WIDTH_M);
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (bus.abort) begin
            state <= ST_IDLE;
          end
`ifdef EARLY_TERM_EN
          else if ((q_q & live_mask) == '0) begin
            // Every remaining step would only shift, so do them all at once.
            {c_q, a_q, q_q} <= {c_q, a_q, q_q} >> rem;
            rem             <= '0;
            state           <= ST_DONE;
          end
`endif
          else begin
            c_q <= 1'b0;
            a_q <= sum[WIDTH_M:1];
            q_q <= {sum[0], q_q[WIDTH_M-1:1]};
            rem <= rem - REM_W'(1);
            if (rem == REM_W'(1)) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.abort || bus.out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // All outputs are decoded from registered state, so none of them depends
  // combinationally on in_valid or out_ready.
  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.product   = {a_q, q_q};

endmodule

// File: tb/tb_seq_mult_engine.sv
// tb_seq_mult_engine: directed and random operand pairs for seq_mult_engine,
// compared against plain integer multiplication and a cycle-count model.
module tb_seq_mult_engine;

  localparam int W      = 16;
  localparam int BUDGET = 200;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;

  seq_mult_engine_if #(.WIDTH_M(W)) bus ();

  seq_mult_engine #(.WIDTH_M(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference product is the plain unsigned multiplication.
  function automatic logic [63:0] ref_product(input logic [W-1:0] m, input logic [W-1:0] q);
    return 64'(m) * 64'(q);
  endfunction

  // Reference CALC cycle count: WIDTH_M normally; with early termination it is
  // 1 for q==0, otherwise min(W, h+2) where h is the top set bit.
  function automatic int exp_cycles(input logic [W-1:0] q);
    int h;
    h = -1;
    for (int i = 0; i < W; i++) if (q[i]) h = i;
`ifdef EARLY_TERM_EN
    if (h < 0) return 1;
    return (h + 2 > W) ? W : h + 2;
`else
    return (h < -1) ? 0 : W;
`endif
  endfunction

  // Present an operand pair in IDLE and let it be accepted on the next edge.
  task automatic start_op(input logic [W-1:0] m, input logic [W-1:0] q);
    @(negedge clk);
    bus.multiplicand = m;
    bus.multiplier   = q;
    bus.in_valid     = 1'b1;
    check("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Count edges after acceptance until out_valid appears, bounded by BUDGET.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < BUDGET) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // A whole operation: accept, latency, product, stall, output handshake.
  task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q, input int stall);
    int          cyc;
    logic [63:0] exp_p;
    exp_p = ref_product(m, q);
    bus.out_ready = 1'b0;
    start_op(m, q);
    check("busy_after_accept", 64'(bus.busy), 64'd1);
    wait_valid(cyc);
    check("latency", 64'(cyc), 64'(exp_cycles(q)));
    check("product", 64'(bus.product), exp_p);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check("stall_out_valid", 64'(bus.out_valid), 64'd1);
      check("stall_product", 64'(bus.product), exp_p);
      check("stall_in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("idle_out_valid", 64'(bus.out_valid), 64'd0);
    check("idle_in_ready", 64'(bus.in_ready), 64'd1);
    check("idle_busy", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int          cyc;
    logic [W-1:0] rm;
    logic [W-1:0] rq;

    vectors          = 0;
    miscompares      = 0;
    reset_n          = 1'b0;
    bus.in_valid     = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    bus.abort        = 1'b0;
    bus.out_ready    = 1'b0;

    // Reset state.
    #12;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_product", 64'(bus.product), 64'd0);
    reset_n = 1'b1;

    // Directed products from the test plan.
    run_op(16'h1234, 16'h5678, 0);
    check("p_1234x5678_const", ref_product(16'h1234, 16'h5678), 64'h0626_0060);
    run_op(16'hFFFF, 16'hFFFF, 0);
    run_op(16'h0003, 16'h0005, 10);

    // Abort is ignored in IDLE.
    @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    check("abort_idle_in_ready", 64'(bus.in_ready), 64'd1);

    // Abort on the 7th CALC cycle.
    start_op(16'h1111, 16'hFFFF);
    repeat (6) @(posedge clk);
    @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    check("abort_calc_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_calc_in_ready", 64'(bus.in_ready), 64'd1);
    check("abort_calc_busy", 64'(bus.busy), 64'd0);

    // Abort in DONE while the consumer is stalled; out_ready is held high too
    // to confirm abort wins the edge.
    start_op(16'h2222, 16'h0101);
    wait_valid(cyc);
    check("abort_done_reached", 64'(bus.out_valid), 64'd1);
    @(negedge clk);
    bus.abort     = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    check("abort_done_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_done_in_ready", 64'(bus.in_ready), 64'd1);
    run_op(16'h00FF, 16'h0100, 0);

    // Asynchronous reset between edges in the middle of CALC.
    start_op(16'hBEEF, 16'hCAFE);
    repeat (5) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_in_ready", 64'(bus.in_ready), 64'd1);
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_product", 64'(bus.product), 64'd0);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("arst_release_in_ready", 64'(bus.in_ready), 64'd1);

    // Early-termination corner operands (full latency when the macro is off).
    run_op(16'hABCD, 16'h0000, 0);
    run_op(16'hABCD, 16'h0003, 1);
    run_op(16'h7777, 16'h8000, 0);
    run_op(16'hFFFF, 16'h0001, 0);

    // Random operand pairs, with the multiplier often narrowed.
    for (int n = 0; n < 24; n++) begin
      rm = W'($urandom);
      rq = W'($urandom) >> $urandom_range(0, W);
      run_op(rm, rq, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_mult_engine.md
# seq_mult_engine

Parametrised shift-add sequential multiplier engine: accepts an unsigned WIDTH_M x WIDTH_M operand pair over a valid/ready handshake and iterates one multiplier bit per cycle. Each cycle performs a conditional add into the accumulator, then a combined {carry, accumulator, multiplier} right shift. The 2*WIDTH_M-bit product is returned over a second valid/ready handshake. It supersedes the separate add and shift stages of the multiplier datapath: it folds both into one controlled loop, with correct carry propagation into the accumulator MSB, abort support and optional early termination.

## Interface
- WIDTH_M, 16, operand width in bits; legal range 2..64.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  engine can accept operands.
- multiplicand  input  WIDTH_M  operand M, unsigned.
- multiplier  input  WIDTH_M  operand Q, unsigned.
- abort  input  1  synchronous cancel of an in-flight operation.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH_M  result {A,Q}.
- busy  output  1  high in CALC or DONE.

## Operation
- Registers:
  - M (WIDTH_M).
  - A (WIDTH_M).
  - Q (WIDTH_M).
  - C (1 bit).
  - rem: remaining bit count, $clog2(WIDTH_M+1) bits.
  - state: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: load M<=multiplicand, Q<=multiplier, A<=0, C<=0, rem<=WIDTH_M; go to CALC.
- CALC, one step per cycle:
  - {C,S} = Q[0] ? A+M : {1'b0,A}, computed at WIDTH_M+1 bits.
  - {C,A,Q} <= {C,S,Q} >> 1, i.e. the carry enters A[WIDTH_M-1], S[0] enters Q[WIDTH_M-1], and C becomes 0.
  - rem <= rem-1. When rem reaches 0, go to DONE.
- DONE:
  - out_valid=1 and product={A,Q}, both held stable until out_ready.
  - On out_ready, go to IDLE.
- abort:
  - In CALC or DONE, abort returns the engine to IDLE on the next edge. No out_valid is produced, or a pending one is dropped.
  - abort has priority over out_ready and over step completion.
  - abort is ignored in IDLE.
- Arithmetic is unsigned. The product never overflows 2*WIDTH_M bits.
- Reset values:
  - state=IDLE, M=A=Q=0, C=0, rem=0.
  - in_ready=1, out_valid=0, product=0, busy=0.
- Reset mid-operation discards all state immediately, with no output.

## Timing
- Handshakes:
  - in_ready=1 only in IDLE, so operands are accepted only there.
  - in_valid in any other state is ignored; the source holds it until in_ready.
  - Acceptance happens at edge E0, when in_valid and in_ready are both high.
- Latency without EARLY_TERM_EN:
  - Exactly WIDTH_M CALC cycles.
  - out_valid rises at edge E0+WIDTH_M+1... corrected: first visible in the cycle after the WIDTH_M-th CALC edge, i.e. at E0+WIDTH_M.
- Stalls: out_valid persists any number of cycles while out_ready=0, with product stable.
- Throughput:
  - The next acceptance is possible no earlier than 1 cycle after the output handshake, since the engine passes through IDLE.
  - Best case is one result per WIDTH_M+2 cycles.
- busy is high from the cycle after acceptance until the cycle of the output handshake or abort.
- Outputs are all registered or decoded from state; there is no combinational path from in_valid/out_ready to any output.

## Configuration
- Macro: EARLY_TERM_EN.
- Undefined: fixed WIDTH_M-cycle iteration as above.
- Defined:
  - At the start of each CALC cycle, if Q[rem-1:0]==0 (no unprocessed multiplier bits set), the engine performs a single shift {C,A,Q} <= {C,A,Q} >> rem and goes to DONE.
  - CALC cycle count is 1 for multiplier==0, otherwise min(WIDTH_M, h+2), where h is the index of the highest set multiplier bit.
  - Product values are identical with and without the macro.
  - abort and the handshake rules are unchanged.

## Test plan
- WIDTH_M=16, M=0x1234, Q=0x5678, out_ready=1 -> product=0x06260060; out_valid exactly 16 cycles after acceptance (macro off).
- M=0xFFFF, Q=0xFFFF -> product=0xFFFE0001; checks carry entry into the accumulator MSB on every step.
- out_ready held 0 for 10 cycles after out_valid -> product stable and in_ready=0 throughout; then out_ready=1 -> IDLE next cycle; a new pair (M=3, Q=5) -> product=0x0000000F.
- abort asserted on CALC cycle 7, then at DONE with out_ready=0 -> both return to IDLE, out_valid never seen; the following pair 0x00FF x 0x0100 -> product=0x0000FF00.
- reset_n pulsed low mid-CALC (asynchronously, between edges) -> all outputs at reset values immediately; in_ready=1 after release.
- EARLY_TERM_EN defined: Q=0 -> 1 CALC cycle, product=0; Q=0x0003, M=0xABCD -> 3 cycles, product=0x00020367; Q=0x8000 -> 16 cycles.
